// File: rtl/aap_regfile.sv
// AAP core register file.
// Three execute-stage ports (a, b, d). Each port has a combinational read and
// a synchronous write. When two or more ports write the same register, port d
// wins over port b, and port b wins over port a.
// After reset, a clear sequence writes zero to every register. The rest of
// the file is unavailable until that sequence finishes.
// A four-phase debug port gives a host read/write access to any register. The
// core always wins: a debug write retries until no core port targets the same
// register.

module aap_regfile #(
   parameter int NREGS = 64,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,

   input  logic [5:0]       rega_rregnum,
   output logic [WIDTH-1:0] rega_rdata,
   input  logic [5:0]       rega_wregnum,
   input  logic [WIDTH-1:0] rega_wdata,
   input  logic             rega_we,

   input  logic [5:0]       regb_rregnum,
   output logic [WIDTH-1:0] regb_rdata,
   input  logic [5:0]       regb_wregnum,
   input  logic [WIDTH-1:0] regb_wdata,
   input  logic             regb_we,

   input  logic [5:0]       regd_rregnum,
   output logic [WIDTH-1:0] regd_rdata,
   input  logic [5:0]       regd_wregnum,
   input  logic [WIDTH-1:0] regd_wdata,
   input  logic             regd_we,

   output logic             ready,

   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [5:0]       dbg_regnum,
   input  logic [WIDTH-1:0] dbg_wdata,
   output logic [WIDTH-1:0] dbg_rdata,
   output logic             dbg_ack
);

   localparam logic [5:0] LAST_REG = 6'(NREGS - 1);

   typedef enum logic {
      MAIN_CLEAR,
      MAIN_RUN
   } mainState_t;

   typedef enum logic [1:0] {
      DBG_IDLE,
      DBG_ACCESS,
      DBG_DONE
   } dbgState_t;

   mainState_t       mainState_q, mainState_d;
   logic [5:0]       clearCnt_q, clearCnt_d;

   dbgState_t        dbgState_q, dbgState_d;
   logic             dbgWe_q, dbgWe_d;
   logic [5:0]       dbgRegnum_q, dbgRegnum_d;
   logic [WIDTH-1:0] dbgWdata_q, dbgWdata_d;
   logic [WIDTH-1:0] dbgRdata_q, dbgRdata_d;
   logic             dbgAck_q, dbgAck_d;
   logic             dbgWrite;
   logic             dbgConflict;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];

   // Full 64-entry view of the register space.
   // Unimplemented register numbers read as zero, so every read needs only a
   // single index into this view.
   logic [WIDTH-1:0] regView [64];

   for (genvar g = 0; g < 64; g++) begin : gView
      if (g < NREGS) begin : gImpl
         assign regView[g] = regs_q[g];
      end else begin : gUnimpl
         assign regView[g] = '0;
      end
   end

   assign ready = (mainState_q == MAIN_RUN);

   // Reads return zero until the clear sequence has completed.
   assign rega_rdata = ready ? regView[rega_rregnum] : '0;
   assign regb_rdata = ready ? regView[regb_rregnum] : '0;
   assign regd_rdata = ready ? regView[regd_rregnum] : '0;

   assign dbg_rdata = dbgRdata_q;
   assign dbg_ack   = dbgAck_q;

   // Main FSM state register: reset restarts the clear sequence from register 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         mainState_q <= MAIN_CLEAR;
         clearCnt_q  <= '0;
      end else begin
         mainState_q <= mainState_d;
         clearCnt_q  <= clearCnt_d;
      end
   end

   // Main FSM next state: step through every register, then enter RUN.
   always_comb begin
      mainState_d = mainState_q;
      clearCnt_d  = clearCnt_q;
      if (mainState_q == MAIN_CLEAR) begin
         clearCnt_d = clearCnt_q + 6'd1;
         if (clearCnt_q == LAST_REG) begin
            mainState_d = MAIN_RUN;
            clearCnt_d  = '0;
         end
      end
   end

   // A debug write conflicts with any core port that targets the captured
   // register number on this edge.
   always_comb begin
      dbgConflict = (rega_we && (rega_wregnum == dbgRegnum_q)) ||
                    (regb_we && (regb_wregnum == dbgRegnum_q)) ||
                    (regd_we && (regd_wregnum == dbgRegnum_q));
   end

   // Debug FSM state register: reset drops ack and abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbgState_q  <= DBG_IDLE;
         dbgWe_q     <= 1'b0;
         dbgRegnum_q <= '0;
         dbgWdata_q  <= '0;
         dbgRdata_q  <= '0;
         dbgAck_q    <= 1'b0;
      end else begin
         dbgState_q  <= dbgState_d;
         dbgWe_q     <= dbgWe_d;
         dbgRegnum_q <= dbgRegnum_d;
         dbgWdata_q  <= dbgWdata_d;
         dbgRdata_q  <= dbgRdata_d;
         dbgAck_q    <= dbgAck_d;
      end
   end

   // Debug FSM next state: capture the request in IDLE, perform the access,
   // then hold ack until the host drops its request. The FSM is frozen while
   // the register file is clearing.
   always_comb begin
      dbgState_d  = dbgState_q;
      dbgWe_d     = dbgWe_q;
      dbgRegnum_d = dbgRegnum_q;
      dbgWdata_d  = dbgWdata_q;
      dbgRdata_d  = dbgRdata_q;
      dbgAck_d    = dbgAck_q;
      dbgWrite    = 1'b0;
      if (ready) begin
         case (dbgState_q)
            DBG_IDLE: begin
               if (dbg_req) begin
                  dbgWe_d     = dbg_we;
                  dbgRegnum_d = dbg_regnum;
                  dbgWdata_d  = dbg_wdata;
                  dbgState_d  = DBG_ACCESS;
               end
            end
            DBG_ACCESS: begin
               if (!dbgWe_q) begin
                  dbgRdata_d = regView[dbgRegnum_q];
                  dbgAck_d   = 1'b1;
                  dbgState_d = DBG_DONE;
               end else if (!dbgConflict) begin
                  dbgWrite   = 1'b1;
                  dbgRdata_d = '0;
                  dbgAck_d   = 1'b1;
                  dbgState_d = DBG_DONE;
               end
            end
            DBG_DONE: begin
               if (!dbg_req) begin
                  dbgAck_d   = 1'b0;
                  dbgState_d = DBG_IDLE;
               end
            end
            default: begin
               dbgAck_d   = 1'b0;
               dbgState_d = DBG_IDLE;
            end
         endcase
      end
   end

   // Per-register next value.
   // During CLEAR, only the register under the clear counter changes.
   // During RUN, a debug write lands only when no core port targets that
   // register. The core ports are applied afterwards in the order a, b, d, so
   // that d has the highest priority.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (mainState_q == MAIN_CLEAR) begin
            if (clearCnt_q == 6'(i)) begin
               regs_d[i] = '0;
            end
         end else begin
            if (dbgWrite && (dbgRegnum_q == 6'(i))) begin
               regs_d[i] = dbgWdata_q;
            end
            if (rega_we && (rega_wregnum == 6'(i))) begin
               regs_d[i] = rega_wdata;
            end
            if (regb_we && (regb_wregnum == 6'(i))) begin
               regs_d[i] = regb_wdata;
            end
            if (regd_we && (regd_wregnum == 6'(i))) begin
               regs_d[i] = regd_wdata;
            end
         end
      end
   end

   // Register storage: nothing is written on a reset edge, and the clear
   // sequence supplies the initial contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_aap_regfile.sv
// Testbench for aap_regfile.
// The stimulus process queues the expected values.
// A monitor running on the falling clock edge pops each queued value and
// compares it with the DUT, and also checks every rising edge of dbg_ack.

module tb_aap_regfile;

   localparam int SEL_A      = 0;
   localparam int SEL_B      = 1;
   localparam int SEL_D      = 2;
   localparam int SEL_READY  = 3;
   localparam int SEL_ACK    = 4;
   localparam int SEL_DRDATA = 5;
   localparam int SEL_SA     = 6;
   localparam int SEL_SB     = 7;
   localparam int SEL_SD     = 8;
   localparam int SEL_SREADY = 9;
   localparam int SEL_SACK   = 10;
   localparam int SEL_SDRD   = 11;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
   } chk_t;

   typedef struct {
      logic        chkData;
      logic [15:0] data;
   } dbgExp_t;

   chk_t    chkQ[$];
   dbgExp_t dbgQ[$];
   int      nChecks = 0;
   int      nFails  = 0;
   logic    ackPrev = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Inputs and outputs of the NREGS=64 instance
   logic [5:0]  aRreg = '0, aWreg = '0, bRreg = '0, bWreg = '0, dRreg = '0, dWreg = '0;
   logic [15:0] aWdata = '0, bWdata = '0, dWdata = '0;
   logic        aWe = 1'b0, bWe = 1'b0, dWe = 1'b0;
   logic [15:0] aRdata, bRdata, dRdata;
   logic        ready;
   logic        dbgReq = 1'b0, dbgWe = 1'b0;
   logic [5:0]  dbgRegnum = '0;
   logic [15:0] dbgWdata = '0;
   logic [15:0] dbgRdata;
   logic        dbgAck;

   // Inputs and outputs of the NREGS=32 instance
   logic [5:0]  sARreg = '0, sAWreg = '0, sBRreg = '0, sBWreg = '0, sDRreg = '0, sDWreg = '0;
   logic [15:0] sAWdata = '0, sBWdata = '0, sDWdata = '0;
   logic        sAWe = 1'b0, sBWe = 1'b0, sDWe = 1'b0;
   logic [15:0] sARdata, sBRdata, sDRdata;
   logic        sReady;
   logic        sDbgReq = 1'b0, sDbgWe = 1'b0;
   logic [5:0]  sDbgRegnum = '0;
   logic [15:0] sDbgWdata = '0;
   logic [15:0] sDbgRdata;
   logic        sDbgAck;

   always #5 clk = ~clk;

   aap_regfile #(.NREGS(64), .WIDTH(16)) u_dut (
      .clk(clk), .rst(rst),
      .rega_rregnum(aRreg), .rega_rdata(aRdata), .rega_wregnum(aWreg), .rega_wdata(aWdata), .rega_we(aWe),
      .regb_rregnum(bRreg), .regb_rdata(bRdata), .regb_wregnum(bWreg), .regb_wdata(bWdata), .regb_we(bWe),
      .regd_rregnum(dRreg), .regd_rdata(dRdata), .regd_wregnum(dWreg), .regd_wdata(dWdata), .regd_we(dWe),
      .ready(ready),
      .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_regnum(dbgRegnum), .dbg_wdata(dbgWdata),
      .dbg_rdata(dbgRdata), .dbg_ack(dbgAck)
   );

   aap_regfile #(.NREGS(32), .WIDTH(16)) u_dut32 (
      .clk(clk), .rst(rst),
      .rega_rregnum(sARreg), .rega_rdata(sARdata), .rega_wregnum(sAWreg), .rega_wdata(sAWdata), .rega_we(sAWe),
      .regb_rregnum(sBRreg), .regb_rdata(sBRdata), .regb_wregnum(sBWreg), .regb_wdata(sBWdata), .regb_we(sBWe),
      .regd_rregnum(sDRreg), .regd_rdata(sDRdata), .regd_wregnum(sDWreg), .regd_wdata(sDWdata), .regd_we(sDWe),
      .ready(sReady),
      .dbg_req(sDbgReq), .dbg_we(sDbgWe), .dbg_regnum(sDbgRegnum), .dbg_wdata(sDbgWdata),
      .dbg_rdata(sDbgRdata), .dbg_ack(sDbgAck)
   );

   function automatic logic [15:0] actualOf(input int sel);
      case (sel)
         SEL_A:      return aRdata;
         SEL_B:      return bRdata;
         SEL_D:      return dRdata;
         SEL_READY:  return {15'd0, ready};
         SEL_ACK:    return {15'd0, dbgAck};
         SEL_DRDATA: return dbgRdata;
         SEL_SA:     return sARdata;
         SEL_SB:     return sBRdata;
         SEL_SD:     return sDRdata;
         SEL_SREADY: return {15'd0, sReady};
         SEL_SACK:   return {15'd0, sDbgAck};
         default:    return sDbgRdata;
      endcase
   endfunction

   // Queue one expected value, to be compared at the next falling edge.
   task automatic checkOutput(input string name, input int sel, input logic [15:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      chkQ.push_back(c);
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Run one complete NREGS=32 debug transaction, with no core conflicts.
   task automatic sDebugTxn(input logic we, input logic [5:0] regnum, input logic [15:0] wdata,
                            input logic chkData, input logic [15:0] expData);
      sDbgReq = 1'b1; sDbgWe = we; sDbgRegnum = regnum; sDbgWdata = wdata;
      checkOutput("s32 ack before request", SEL_SACK, 16'd0);
      applyStimulus();
      checkOutput("s32 ack during access", SEL_SACK, 16'd0);
      applyStimulus();
      checkOutput("s32 ack asserted", SEL_SACK, 16'd1);
      if (chkData) checkOutput("s32 debug read data", SEL_SDRD, expData);
      sDbgReq = 1'b0;
      applyStimulus();
      checkOutput("s32 ack dropped", SEL_SACK, 16'd0);
      applyStimulus();
   endtask

   // Monitor: drain the expected-value queue, and check each rising edge of the main debug ack.
   always @(negedge clk) begin
      chk_t    c;
      dbgExp_t d;
      logic [15:0] act;
      while (chkQ.size() > 0) begin
         c = chkQ.pop_front();
         act = actualOf(c.sel);
         nChecks++;
         if (act !== c.exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
         end
      end
      if (dbgAck === 1'b1 && ackPrev !== 1'b1) begin
         nChecks++;
         if (dbgQ.size() == 0) begin
            nFails++;
            $display("[TB] FAIL unexpected dbg_ack: got 1 expected 0 at %0t", $time);
         end else begin
            d = dbgQ.pop_front();
            if (d.chkData && dbgRdata !== d.data) begin
               nFails++;
               $display("[TB] FAIL dbg_rdata on ack: got %h expected %h at %0t", dbgRdata, d.data, $time);
            end
         end
      end
      ackPrev = dbgAck;
   end

   initial begin
      dbgExp_t de;
      $display("[TB] Starting aap_regfile test");

      // Reset state
      applyStimulus();
      checkOutput("reset ready", SEL_READY, 16'd0);
      checkOutput("reset dbg_ack", SEL_ACK, 16'd0);
      checkOutput("reset dbg_rdata", SEL_DRDATA, 16'd0);
      checkOutput("reset rega_rdata", SEL_A, 16'd0);
      applyStimulus();
      rst = 1'b0;

      // First clear, aborted by a reset at cycle 20
      for (int c = 1; c <= 20; c++) begin
         applyStimulus();
         checkOutput("clear1 ready", SEL_READY, 16'd0);
      end
      rst = 1'b1;
      applyStimulus();
      checkOutput("mid-clear reset ready", SEL_READY, 16'd0);
      rst = 1'b0;

      // Full clear: ready rises exactly 64 edges after reset is released.
      // Writes and debug requests made during the clear must be ignored.
      for (int c = 1; c <= 64; c++) begin
         applyStimulus();
         checkOutput("clear2 ready timing", SEL_READY, (c == 64) ? 16'd1 : 16'd0);
         checkOutput("clear2 dbg_ack", SEL_ACK, 16'd0);
         if (c == 5) begin
            aWe = 1'b1; aWreg = 6'd2; aWdata = 16'hBEEF; aRreg = 6'd2;
            dbgReq = 1'b1; dbgWe = 1'b1; dbgRegnum = 6'd3; dbgWdata = 16'h3333;
         end
         if (c > 5 && c < 30) checkOutput("read while clearing", SEL_A, 16'd0);
         if (c == 30) begin
            aWe = 1'b0; dbgReq = 1'b0; dbgWe = 1'b0;
         end
      end

      // Every register reads zero on all ports
      for (int i = 0; i < 64; i++) begin
         aRreg = 6'(i); bRreg = 6'(63 - i); dRreg = 6'(i);
         checkOutput("post-clear rega", SEL_A, 16'd0);
         checkOutput("post-clear regb", SEL_B, 16'd0);
         checkOutput("post-clear regd", SEL_D, 16'd0);
         applyStimulus();
      end
      checkOutput("idle dbg_ack", SEL_ACK, 16'd0);

      // Triple write to distinct registers: no bypass in the write cycle
      aWe = 1'b1; aWreg = 6'd1; aWdata = 16'h1111; aRreg = 6'd1;
      bWe = 1'b1; bWreg = 6'd2; bWdata = 16'h2222; bRreg = 6'd2;
      dWe = 1'b1; dWreg = 6'd3; dWdata = 16'h3333; dRreg = 6'd3;
      checkOutput("triple old a", SEL_A, 16'd0);
      checkOutput("triple old b", SEL_B, 16'd0);
      checkOutput("triple old d", SEL_D, 16'd0);
      applyStimulus();
      aWe = 1'b0; bWe = 1'b0; dWe = 1'b0;
      checkOutput("triple new a", SEL_A, 16'h1111);
      checkOutput("triple new b", SEL_B, 16'h2222);
      checkOutput("triple new d", SEL_D, 16'h3333);
      applyStimulus();

      // Collisions: d beats b and a, and b beats a
      aWe = 1'b1; aWreg = 6'd5; aWdata = 16'hAAAA;
      bWe = 1'b1; bWreg = 6'd5; bWdata = 16'hBBBB;
      dWe = 1'b1; dWreg = 6'd5; dWdata = 16'hDDDD;
      applyStimulus();
      dWe = 1'b0;
      aRreg = 6'd5; dRreg = 6'd5;
      checkOutput("collision abd", SEL_A, 16'hDDDD);
      checkOutput("collision abd port d read", SEL_D, 16'hDDDD);
      applyStimulus();
      aWe = 1'b0; bWe = 1'b0;
      checkOutput("collision ab", SEL_A, 16'hBBBB);
      applyStimulus();

      // Debug read of r7. Changing dbg_regnum after the capture has no effect.
      aWe = 1'b1; aWreg = 6'd7; aWdata = 16'h1234;
      applyStimulus();
      aWe = 1'b0;
      dbgReq = 1'b1; dbgWe = 1'b0; dbgRegnum = 6'd7;
      de.chkData = 1'b1; de.data = 16'h1234; dbgQ.push_back(de);
      checkOutput("dbg read ack pre", SEL_ACK, 16'd0);
      applyStimulus();
      dbgRegnum = 6'd1;
      checkOutput("dbg read ack access", SEL_ACK, 16'd0);
      applyStimulus();
      checkOutput("dbg read ack", SEL_ACK, 16'd1);
      checkOutput("dbg read data", SEL_DRDATA, 16'h1234);
      applyStimulus();
      checkOutput("dbg read ack hold1", SEL_ACK, 16'd1);
      checkOutput("dbg read data hold", SEL_DRDATA, 16'h1234);
      applyStimulus();
      checkOutput("dbg read ack hold2", SEL_ACK, 16'd1);
      dbgReq = 1'b0;
      applyStimulus();
      checkOutput("dbg read ack drop", SEL_ACK, 16'd0);
      applyStimulus();

      // A debug read sees the old value when a port writes the same register on that edge
      dbgReq = 1'b1; dbgWe = 1'b0; dbgRegnum = 6'd7;
      de.chkData = 1'b1; de.data = 16'h1234; dbgQ.push_back(de);
      applyStimulus();
      dWe = 1'b1; dWreg = 6'd7; dWdata = 16'h9999;
      applyStimulus();
      dWe = 1'b0;
      aRreg = 6'd7;
      checkOutput("dbg read same-edge port write", SEL_DRDATA, 16'h1234);
      checkOutput("port write after dbg read", SEL_A, 16'h9999);
      checkOutput("dbg read2 ack", SEL_ACK, 16'd1);
      dbgReq = 1'b0;
      applyStimulus();
      checkOutput("dbg read2 ack drop", SEL_ACK, 16'd0);
      applyStimulus();

      // Debug write to r9 blocked for 3 cycles by port d
      dbgReq = 1'b1; dbgWe = 1'b1; dbgRegnum = 6'd9; dbgWdata = 16'h5555;
      de.chkData = 1'b0; de.data = 16'h0000; dbgQ.push_back(de);
      applyStimulus();
      dbgWdata = 16'hFFFF;
      dWe = 1'b1; dWreg = 6'd9; dWdata = 16'h0F0F;
      for (int k = 1; k <= 3; k++) begin
         applyStimulus();
         checkOutput("dbg write conflict ack withheld", SEL_ACK, 16'd0);
      end
      dWe = 1'b0;
      aRreg = 6'd9;
      checkOutput("port wins conflict", SEL_A, 16'h0F0F);
      applyStimulus();
      checkOutput("dbg write ack", SEL_ACK, 16'd1);
      checkOutput("dbg write landed", SEL_A, 16'h5555);
      dbgReq = 1'b0;
      applyStimulus();
      checkOutput("dbg write ack drop", SEL_ACK, 16'd0);
      applyStimulus();

      // NREGS=32 instance: unimplemented registers, and no aliasing of 40 onto 8
      checkOutput("s32 ready", SEL_SREADY, 16'd1);
      sAWe = 1'b1; sAWreg = 6'd40; sAWdata = 16'hABCD;
      sBWe = 1'b1; sBWreg = 6'd31; sBWdata = 16'h3131;
      applyStimulus();
      sAWe = 1'b0; sBWe = 1'b0;
      sARreg = 6'd40; sBRreg = 6'd31; sDRreg = 6'd8;
      checkOutput("s32 read unimplemented", SEL_SA, 16'd0);
      checkOutput("s32 read last reg", SEL_SB, 16'h3131);
      checkOutput("s32 no alias write", SEL_SD, 16'd0);
      applyStimulus();
      sDebugTxn(1'b1, 6'd40, 16'h7777, 1'b0, 16'd0);
      checkOutput("s32 dbg write unimpl no alias", SEL_SD, 16'd0);
      checkOutput("s32 dbg write unimpl reads 0", SEL_SA, 16'd0);
      sDebugTxn(1'b0, 6'd31, 16'd0, 1'b1, 16'h3131);
      sDebugTxn(1'b0, 6'd40, 16'd0, 1'b1, 16'h0000);

      // Reset during a debug access: no ack, and a full clear follows
      dbgReq = 1'b1; dbgWe = 1'b1; dbgRegnum = 6'd12; dbgWdata = 16'h6666;
      applyStimulus();
      rst = 1'b1; dbgReq = 1'b0; dbgWe = 1'b0;
      applyStimulus();
      checkOutput("mid-debug reset ready", SEL_READY, 16'd0);
      checkOutput("mid-debug reset ack", SEL_ACK, 16'd0);
      rst = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         applyStimulus();
         checkOutput("clear3 ready timing", SEL_READY, (c == 64) ? 16'd1 : 16'd0);
         checkOutput("clear3 dbg_ack", SEL_ACK, 16'd0);
      end
      aRreg = 6'd1; bRreg = 6'd7; dRreg = 6'd12;
      checkOutput("after reclear r1", SEL_A, 16'd0);
      checkOutput("after reclear r7", SEL_B, 16'd0);
      checkOutput("after reclear r12", SEL_D, 16'd0);
      applyStimulus();
      applyStimulus();

      nChecks++;
      if (dbgQ.size() != 0) begin
         nFails++;
         $display("[TB] FAIL pending debug acks: got %0d outstanding expected 0", dbgQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/aap_regfile.md
Name: aap_regfile

Overview:
Register file for the AAP FPGA core, serving the three register ports (a, b, d) that the execute stage drives. It provides combinational reads and synchronous writes on all three ports in the same cycle, with a fixed priority when ports collide. After reset it runs a hardware clear sequence over every register. A four-phase debug port lets an external host read or write any register while the core is running.

Parameters:
NREGS, 64, number of implemented registers (1..64); register numbers >= NREGS are unimplemented.
WIDTH, 16, register data width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
rega_rregnum  input  6  port a read register number
rega_rdata  output  WIDTH  port a read data (combinational)
rega_wregnum  input  6  port a write register number
rega_wdata  input  WIDTH  port a write data
rega_we  input  1  port a write enable
regb_rregnum, regb_rdata, regb_wregnum, regb_wdata, regb_we  as port a, for port b
regd_rregnum, regd_rdata, regd_wregnum, regd_wdata, regd_we  as port a, for port d
ready  output  1  high once the clear sequence completes
dbg_req  input  1  debug request (four-phase)
dbg_we  input  1  debug write (1) / read (0); sampled with dbg_req
dbg_regnum  input  6  debug register number
dbg_wdata  input  WIDTH  debug write data
dbg_rdata  output  WIDTH  debug read data; valid while dbg_ack is high
dbg_ack  output  1  debug acknowledge

Behaviour:
- Reset (rst=1 at a posedge):
  - ready=0, dbg_ack=0, dbg_rdata=0.
  - Clear counter set to 0; main FSM to CLEAR; debug FSM to IDLE.
  - rst asserted mid-clear or mid-debug-transaction aborts it and restarts the clear from register 0.
- CLEAR state:
  - Each cycle writes 0 to reg[cnt], then cnt+1.
  - The write of reg[NREGS-1] moves the FSM to RUN, with ready=1 from that edge.
  - First cycle after rst deasserts to ready high: exactly NREGS cycles.
  - While ready=0: all rdata outputs read 0, port writes are ignored, dbg_req is not sampled.
- RUN state, reads:
  - x_rdata = reg[x_rregnum] combinationally.
  - Returns 0 if x_rregnum >= NREGS.
  - No write-to-read bypass: a read in the same cycle as a write to that register returns the old value; the new value is visible the following cycle.
- RUN state, writes:
  - On a posedge, each port with x_we=1 and x_wregnum < NREGS writes x_wdata.
  - Ports targeting distinct registers all write in the same cycle.
  - Same register targeted by more than one port: priority d > b > a; only the highest-priority data lands.
  - Writes to regnum >= NREGS are dropped silently.
- Debug FSM (advances only while ready=1):
  - IDLE: at a posedge with dbg_req=1, capture dbg_we, dbg_regnum, dbg_wdata; go to ACCESS.
  - ACCESS, read: dbg_rdata <= reg[captured regnum] (0 if unimplemented); dbg_ack <= 1; go to DONE. The read sees the register value before any same-edge port write.
  - ACCESS, write, no conflict: if no port writes the captured regnum this edge, write it, set dbg_ack <= 1, go to DONE.
  - ACCESS, write, conflict: if any port writes the same regnum this edge, the debug write loses and the FSM stays in ACCESS, retrying each cycle. The core always has priority over debug.
  - DONE: dbg_ack and dbg_rdata hold while dbg_req=1. When dbg_req=0 is sampled, dbg_ack <= 0 and go to IDLE.
  - A new request is accepted only after ack has dropped.
  - Conflict-free latency: dbg_req high before edge N → ACCESS after N → dbg_ack high after edge N+1.
  - Inputs other than dbg_req are sampled only in IDLE; later changes are ignored.
- No X propagates: every output is driven in all states.

Test Plan:
- Reset then idle: assert rst 1 cycle, release → ready low for exactly 64 cycles, then high; every port reads 0 for regnums 0..63; dbg_ack stays 0.
- Triple write: ports a, b, d write r1=0x1111, r2=0x2222, r3=0x3333 on one edge, read-back the same cycle → old values (0). Next cycle → 0x1111, 0x2222, 0x3333.
- Collision: a, b, d all write r5 with 0xAAAA, 0xBBBB, 0xDDDD → r5=0xDDDD. Repeat with only a and b writing → r5=0xBBBB.
- Debug read: r7=0x1234; hold dbg_req=1, dbg_we=0, dbg_regnum=7 → dbg_ack high 2 edges later with dbg_rdata=0x1234. Ack stays high until req drops, then falls 1 cycle after.
- Debug write conflict: debug write r9=0x5555 while regd writes r9=0x0F0F for 3 consecutive cycles → ack withheld for those cycles. Then r9=0x5555 and ack asserts on the first free cycle; a regnum of 40 or above with NREGS=32 is acked and has no effect.
- Reset mid-clear and mid-debug: rst at clear cycle 20, and again during ACCESS → clear restarts from 0, ready after 64 further cycles; dbg_ack=0 throughout, with no debug write performed.
